// File: rtl/sample_demux_1to4.sv
// 1:4 round-robin sample deserializer. Packs four successive accepted samples
// into one word and hands the word downstream over a valid/ready handshake.
module sample_demux_1to4 #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                resync,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DATA_W-1:0] out_data,
  output logic [1:0]          lane_ptr,
  output logic [CNT_W-1:0]    word_cnt
);

  // Lane 3 never needs storage: it is written straight into out_data.
  logic [2:0][DATA_W-1:0] acc;
  logic                   accept;
  logic                   complete;
  logic                   handoff;

  // Only the completing sample can stall, and only behind an unconsumed word.
  assign in_ready = resync || (lane_ptr != 2'd3) || !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign complete = accept && !resync && (lane_ptr == 2'd3);
  assign handoff  = out_valid && out_ready;

  // NOTE: every register here uses <= so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the three-entry accumulator is reset as well; it is tiny flop storage, not a RAM.
      acc       <= '0;
      lane_ptr  <= 2'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      word_cnt  <= '0;
    end else begin
      if (resync) begin
        acc      <= '0;
        lane_ptr <= 2'd0;
      end else if (accept) begin
        case (lane_ptr)
          2'd0:    acc[0] <= in_data;
          2'd1:    acc[1] <= in_data;
          2'd2:    acc[2] <= in_data;
          default: ;
        endcase
        lane_ptr <= lane_ptr + 2'd1;
      end

      // A new word may replace the one being handed off in the same cycle.
      if (complete) begin
        out_data  <= {in_data, acc[2], acc[1], acc[0]};
        out_valid <= 1'b1;
      end else if (handoff) begin
        out_valid <= 1'b0;
      end

      if (handoff) begin
        word_cnt <= word_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sample_demux_1to4.sv
// Directed bench for sample_demux_1to4: expected words are queued by the
// stimulus thread and popped by a monitor on every output handshake.
module tb_sample_demux_1to4;

  localparam int DATA_W = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        resync;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        out_ready;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  lane_ptr;
  logic [15:0] word_cnt;

  logic        in_ready_w;
  logic        out_valid_w;
  logic [31:0] out_data_w;
  logic [1:0]  lane_ptr_w;
  logic [3:0]  word_cnt_w;

  int checks = 0;
  int errors = 0;
  int stalls = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  sample_demux_1to4 #(.DATA_W(DATA_W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .resync(resync), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .lane_ptr(lane_ptr),
    .word_cnt(word_cnt)
  );

  // Narrow-counter instance on the same stimulus, for the wrap check.
  sample_demux_1to4 #(.DATA_W(DATA_W), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .resync(resync), .in_valid(in_valid),
    .in_ready(in_ready_w), .in_data(in_data), .out_valid(out_valid_w),
    .out_ready(out_ready), .out_data(out_data_w), .lane_ptr(lane_ptr_w),
    .word_cnt(word_cnt_w)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Handshake one sample; inputs change 1 time unit after the rising edge.
  task automatic send(input logic [7:0] d, input logic rs);
    int budget = 0;
    in_valid = 1'b1;
    in_data  = d;
    resync   = rs;
    @(negedge clk);
    if (!in_ready) stalls++;
    while (!in_ready && budget < 50) begin
      budget++;
      @(negedge clk);
    end
    check("send_timeout", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    resync   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", out_data, 32'hxxxx_xxxx);
      end else begin
        check("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; resync = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    idle(2);
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_lane_ptr", lane_ptr, 2'd0);
    check("rst_word_cnt", word_cnt, 16'd0);
    check("rst_out_data", out_data, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // 1) single word, one-cycle latency
    exp_q.push_back(32'h44332211);
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
    check("t1_out_valid_latency", out_valid, 1'b1);
    idle(1);
    check("t1_word_cnt", word_cnt, 16'd1);
    check("t1_out_valid_clear", out_valid, 1'b0);

    // 2) twelve back-to-back samples, no input stall
    exp_q.push_back(32'h04030201);
    exp_q.push_back(32'h08070605);
    exp_q.push_back(32'h0C0B0A09);
    stalls = 0;
    for (int i = 1; i <= 12; i++) send(8'(i), 1'b0);
    check("t2_no_stall", stalls, 0);
    idle(2);
    check("t2_word_cnt", word_cnt, 16'd4);

    // 3) backpressure: only the completing sample waits
    out_ready = 1'b0;
    exp_q.push_back(32'h14131211);
    exp_q.push_back(32'h24232221);
    stalls = 0;
    send(8'h11, 1'b0); send(8'h12, 1'b0); send(8'h13, 1'b0); send(8'h14, 1'b0);
    send(8'h21, 1'b0); send(8'h22, 1'b0); send(8'h23, 1'b0);
    check("t3_no_stall_lanes012", stalls, 0);
    in_valid = 1'b1;
    in_data  = 8'h24;
    idle(3);
    @(negedge clk);
    check("t3_in_ready_low", in_ready, 1'b0);
    check("t3_lane_ptr", lane_ptr, 2'd3);
    check("t3_out_data_held", out_data, 32'h14131211);
    check("t3_out_valid_held", out_valid, 1'b1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(8'h24, 1'b0);
    check("t3_back_to_back_valid", out_valid, 1'b1);
    idle(2);
    check("t3_word_cnt", word_cnt, 16'd6);

    // 4) resync drops the partial word and the sample presented with it
    exp_q.push_back(32'hB4B3B2B1);
    send(8'hA1, 1'b0); send(8'hA2, 1'b0);
    send(8'hFF, 1'b1);
    check("t4_lane_ptr_after_resync", lane_ptr, 2'd0);
    send(8'hB1, 1'b0); send(8'hB2, 1'b0); send(8'hB3, 1'b0); send(8'hB4, 1'b0);
    idle(2);
    check("t4_word_cnt", word_cnt, 16'd7);

    // 5) reset overrides a pending word and a partial word
    out_ready = 1'b0;
    send(8'hC1, 1'b0); send(8'hC2, 1'b0); send(8'hC3, 1'b0); send(8'hC4, 1'b0);
    send(8'hD1, 1'b0); send(8'hD2, 1'b0);
    check("t5_pre_lane_ptr", lane_ptr, 2'd2);
    check("t5_pre_out_valid", out_valid, 1'b1);
    rst = 1'b1;
    idle(1);
    check("t5_out_valid", out_valid, 1'b0);
    check("t5_lane_ptr", lane_ptr, 2'd0);
    check("t5_word_cnt", word_cnt, 16'd0);
    check("t5_out_data", out_data, 32'h0);
    rst = 1'b0;
    out_ready = 1'b1;

    // 6) 17 words: the 4-bit counter wraps through 0 to 1
    for (int k = 0; k < 17; k++) begin
      exp_q.push_back({8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
    end
    for (int i = 0; i < 68; i++) send(8'(i), 1'b0);
    idle(2);
    check("t6_word_cnt_wrap", word_cnt_w, 4'd1);
    check("t6_word_cnt_wide", word_cnt, 16'd17);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
